clock_tick_scheduler: RTL and testbench



---
 rtl/clkdiv_pkg.sv | 24 ++
 rtl/tick_prescaler.sv | 48 ++++
 rtl/clock_tick_scheduler.sv | 134 +++++++++++++
 tb/tb_clock_tick_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clock-enable tick scheduler.
//   TAP_MAX   highest legal rate tap (period 2^(TAP_MAX+1) base ticks)
//   CNT_W     width of the shared power-of-two counter
//   SEL_W     width of a rate tap select
//   tap_mask  low-order counter bits that must all be ones for tap k to tick
package clkdiv_pkg;

    localparam int unsigned TAP_MAX = 20;
    localparam int unsigned CNT_W   = 21;
    localparam int unsigned SEL_W   = 5;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } sched_state_t;

    typedef logic [SEL_W-1:0] tap_sel_t;

    // Tap k looks at count[k:0]; only legal taps (0..TAP_MAX) are ever stored.
    function automatic logic [CNT_W-1:0] tap_mask(input tap_sel_t sel);
        return {CNT_W{1'b1}} >> (TAP_MAX - 32'(sel));
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler plus shared tick counter.
//   clock_50MHz  sole clock
//   reset        asynchronous, active-high reset
//   base_tick    registered one-cycle pulse every PRESCALE cycles
//   count        counter of base ticks, advanced on each cycle base_tick is high
module tick_prescaler
    import clkdiv_pkg::*;
#(
    parameter int unsigned PRESCALE = 24
) (
    input  logic             clock_50MHz,
    input  logic             reset,
    output logic             base_tick,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]  presc_q, presc_d;
    logic             base_tick_q, base_tick_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             presc_wrap;

    always_comb begin
        presc_wrap  = (presc_q == PS_W'(PRESCALE - 1));
        presc_d     = presc_wrap ? '0 : presc_q + PS_W'(1);
        base_tick_d = presc_wrap;
        // The count advances at the end of the base_tick cycle, so decoders
        // in that cycle see the pre-increment value.
        count_d     = count_q + {{(CNT_W-1){1'b0}}, base_tick_q};
    end

    always_ff @(posedge clock_50MHz or posedge reset) begin
        if (reset) begin
            presc_q     <= '0;
            base_tick_q <= 1'b0;
            count_q     <= '0;
        end else begin
            presc_q     <= presc_d;
            base_tick_q <= base_tick_d;
            count_q     <= count_d;
        end
    end

    assign base_tick = base_tick_q;
    assign count     = count_q;

endmodule

// File: rtl/clock_tick_scheduler.sv
// Single-clock tick scheduler: hands out one-cycle clock-enable ticks to
// N_CH requesters, each on its own power-of-two rate tap of a shared counter.
// Rate/enable changes are taken over a valid/ready port and applied only at
// the target channel's period boundary.
//   clock_50MHz  sole clock
//   reset        asynchronous, active-high reset
//   cfg_valid    config request valid
//   cfg_ready    scheduler can accept a config (idle)
//   cfg_ch       target channel
//   cfg_sel      rate tap k, legal 0..20
//   cfg_en       1 = run channel, 0 = stop it
//   cfg_done     one-cycle pulse after a config is applied
//   cfg_err      one-cycle pulse after a config is rejected
//   base_tick    one-cycle pulse every PRESCALE cycles
//   tick_o       per-channel one-cycle enable pulses
//   ch_active    per-channel enable register
module clock_tick_scheduler
    import clkdiv_pkg::*;
#(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned PRESCALE = 24,
    parameter int unsigned CH_W     = 2
) (
    input  logic            clock_50MHz,
    input  logic            reset,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CH_W-1:0] cfg_ch,
    input  logic [4:0]      cfg_sel,
    input  logic            cfg_en,
    output logic            cfg_done,
    output logic            cfg_err,
    output logic            base_tick,
    output logic [N_CH-1:0] tick_o,
    output logic [N_CH-1:0] ch_active
);

    logic [CNT_W-1:0] count;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock_50MHz (clock_50MHz),
        .reset       (reset),
        .base_tick   (base_tick),
        .count       (count)
    );

    logic [N_CH-1:0]            en_q, en_d;
    logic [N_CH-1:0][SEL_W-1:0] sel_q, sel_d;
    sched_state_t               state_q, state_d;
    logic [CH_W-1:0]            pend_ch_q, pend_ch_d;
    tap_sel_t                   pend_sel_q, pend_sel_d;
    logic                       pend_en_q, pend_en_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic                       cfg_bad;

    // Zero-latency decode of registered state; channels on the same tap
    // share the counter and therefore tick in the same cycle.
    always_comb begin
        for (int i = 0; i < int'(N_CH); i++) begin
            tick_o[i] = base_tick & en_q[i] &
                        ((count & tap_mask(sel_q[i])) == tap_mask(sel_q[i]));
        end
    end

    always_comb begin
        cfg_bad    = (cfg_sel > SEL_W'(TAP_MAX)) || (32'(cfg_ch) >= N_CH);
        state_d    = state_q;
        pend_ch_d  = pend_ch_q;
        pend_sel_d = pend_sel_q;
        pend_en_d  = pend_en_q;
        en_d       = en_q;
        sel_d      = sel_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        pend_ch_d  = cfg_ch;
                        pend_sel_d = cfg_sel;
                        pend_en_d  = cfg_en;
                        state_d    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A running channel switches only in its own tick cycle, so
                // the boundary tick still goes out at the old rate.
                for (int i = 0; i < int'(N_CH); i++) begin
                    if (pend_ch_q == CH_W'(i) && (!en_q[i] || tick_o[i])) begin
                        en_d[i]  = pend_en_q;
                        sel_d[i] = pend_sel_q;
                        done_d   = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_50MHz or posedge reset) begin
        if (reset) begin
            en_q       <= '0;
            sel_q      <= '0;
            state_q    <= S_IDLE;
            pend_ch_q  <= '0;
            pend_sel_q <= '0;
            pend_en_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            en_q       <= en_d;
            sel_q      <= sel_d;
            state_q    <= state_d;
            pend_ch_q  <= pend_ch_d;
            pend_sel_q <= pend_sel_d;
            pend_en_q  <= pend_en_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cfg_ready = (state_q == S_IDLE);
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign ch_active = en_q;

endmodule

// File: tb/tb_clock_tick_scheduler.sv
module tb_clock_tick_scheduler;

    localparam int P  = 4;
    localparam int PB = 24;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [4:0] cfg_sel = '0;
    logic       cfg_en = 1'b0;
    logic       cfg_ready, cfg_done, cfg_err, base_tick;
    logic [3:0] tick_o, ch_active;

    logic       b_valid = 1'b0;
    logic [1:0] b_ch = '0;
    logic [4:0] b_sel = '0;
    logic       b_en = 1'b0;
    logic       b_ready, b_done, b_err, b_base;
    logic [2:0] b_tick, b_active;

    clock_tick_scheduler #(.N_CH(4), .PRESCALE(P), .CH_W(2)) dut (
        .clock_50MHz (clk),       .reset     (reset),
        .cfg_valid   (cfg_valid), .cfg_ready (cfg_ready),
        .cfg_ch      (cfg_ch),    .cfg_sel   (cfg_sel),
        .cfg_en      (cfg_en),    .cfg_done  (cfg_done),
        .cfg_err     (cfg_err),   .base_tick (base_tick),
        .tick_o      (tick_o),    .ch_active (ch_active)
    );

    clock_tick_scheduler #(.N_CH(3), .PRESCALE(PB), .CH_W(2)) dut_b (
        .clock_50MHz (clk),     .reset     (reset),
        .cfg_valid   (b_valid), .cfg_ready (b_ready),
        .cfg_ch      (b_ch),    .cfg_sel   (b_sel),
        .cfg_en      (b_en),    .cfg_done  (b_done),
        .cfg_err     (b_err),   .base_tick (b_base),
        .tick_o      (b_tick),  .ch_active (b_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc;

    // Cycle 0 is the first cycle after reset release.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out at cycle %0d, awaited event never seen", name, cyc);
    endtask

    // ---------------- behavioural model ----------------
    // Base ticks fall on cycles P, 2P, ...; the counter seen in cycle c is the
    // number of earlier base ticks. Tap k fires when (count+1) is a multiple
    // of 2^(k+1).
    logic [3:0]      m_en;
    logic [3:0][4:0] m_sel;
    bit              m_wait, m_done, m_err, nd, ne, bt;
    int              m_ch, cnt;
    logic [4:0]      m_psel;
    bit              m_pen;
    logic [3:0]      et;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_base", base_tick, 0);  chk("rst_tick", tick_o, 0);
            chk("rst_ready", cfg_ready, 1); chk("rst_done", cfg_done, 0);
            chk("rst_err", cfg_err, 0);     chk("rst_active", ch_active, 0);
            chk("rst_b_base", b_base, 0);   chk("rst_b_ready", b_ready, 1);
            chk("rst_b_active", b_active, 0);
            m_en = '0; m_sel = '0; m_wait = 0; m_done = 0; m_err = 0;
        end else begin
            bt  = (cyc > 0) && (cyc % P == 0);
            cnt = (cyc == 0) ? 0 : ((cyc - 1) / P) % (1 << 21);
            for (int i = 0; i < 4; i++)
                et[i] = bt && m_en[i] && (((cnt + 1) % (1 << (m_sel[i] + 1))) == 0);
            chk("base_tick", base_tick, bt);
            chk("tick_o", tick_o, et);
            chk("cfg_ready", cfg_ready, !m_wait);
            chk("cfg_done", cfg_done, m_done);
            chk("cfg_err", cfg_err, m_err);
            chk("ch_active", ch_active, m_en);
            chk("b_base_tick", b_base, (cyc > 0) && (cyc % PB == 0));
            nd = 0; ne = 0;
            if (!m_wait) begin
                if (cfg_valid) begin
                    if (cfg_sel > 20) ne = 1;
                    else begin
                        m_wait = 1; m_ch = int'(cfg_ch); m_psel = cfg_sel; m_pen = cfg_en;
                    end
                end
            end else if (!m_en[m_ch] || et[m_ch]) begin
                m_en[m_ch] = m_pen; m_sel[m_ch] = m_psel; m_wait = 0; nd = 1;
            end
            m_done = nd; m_err = ne;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_cfg(input int ch, input int sel, input bit en, output int acc);
        acc = -1;
        @(posedge clk); #1;
        cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_sel = 5'(sel); cfg_en = en;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (cfg_ready) begin acc = cyc; break; end
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        if (acc < 0) fail_timeout("cfg_accept");
    endtask

    task automatic wait_done(input int ch, output int dc, output int nt, output int lt);
        dc = -1; nt = 0; lt = -1;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (tick_o[ch]) begin nt++; lt = cyc; end
            if (cfg_done) begin dc = cyc; break; end
        end
        if (dc < 0) fail_timeout("cfg_done_wait");
    endtask

    task automatic next_tick(input int ch, output int tc);
        tc = -1;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (tick_o[ch]) begin tc = cyc; break; end
        end
        if (tc < 0) fail_timeout("tick_wait");
    endtask

    task automatic b_send(input int ch, input int sel);
        @(posedge clk); #1;
        b_valid = 1'b1; b_ch = 2'(ch); b_sel = 5'(sel); b_en = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0;
    endtask

    int t, d, n, l, t1, t2, cnt_a, cnt_b;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // First base ticks: cycle P on the main instance, cycle 24 on dut_b.
        for (int k = 0; k < 100; k++) begin @(negedge clk); if (base_tick) break; end
        chk("first_base_p4", cyc, 4);
        for (int k = 0; k < 100; k++) begin @(negedge clk); if (b_base) break; end
        chk("first_base_p24", cyc, 24);
        for (int k = 0; k < 100; k++) begin @(negedge clk); if (b_base) break; end
        chk("second_base_p24", cyc, 48);

        // Rejections on the 3-channel instance: channel 3, then tap 21.
        b_send(3, 0);
        @(negedge clk);
        chk("b_err_ch", b_err, 1); chk("b_ready_ch", b_ready, 1); chk("b_active_ch", b_active, 0);
        b_send(0, 21);
        @(negedge clk);
        chk("b_err_sel", b_err, 1); chk("b_ready_sel", b_ready, 1); chk("b_active_sel", b_active, 0);
        @(negedge clk);
        chk("b_err_pulse", b_err, 0);
        // Legal config on a disabled channel: done two cycles after acceptance.
        b_send(2, 0);
        @(negedge clk);
        chk("b_done_t1", b_done, 0); chk("b_ready_t1", b_ready, 0);
        @(negedge clk);
        chk("b_done_t2", b_done, 1); chk("b_ready_t2", b_ready, 1); chk("b_active_t2", b_active, 3'b100);

        // Enable from idle.
        send_cfg(0, 0, 1'b1, t);
        wait_done(0, d, n, l);
        chk("en_done_latency", d - t, 2);
        next_tick(0, t1); next_tick(0, t2);
        chk("ch0_sel0_period", t2 - t1, 8);

        // Rate change on a running channel.
        send_cfg(1, 3, 1'b1, t);
        wait_done(1, d, n, l);
        repeat (20) @(negedge clk);
        send_cfg(1, 1, 1'b1, t);
        wait_done(1, d, n, l);
        chk("rate_ticks_in_wait", n, 1);
        chk("rate_boundary_tick", l, d - 1);
        next_tick(1, t1); next_tick(1, t2);
        chk("rate_first_new", t1 - (d - 1), 16);
        chk("rate_new_period", t2 - t1, 16);

        // Disable waits for exactly one final tick.
        send_cfg(2, 2, 1'b1, t);
        wait_done(2, d, n, l);
        send_cfg(2, 2, 1'b0, t);
        wait_done(2, d, n, l);
        chk("dis_last_ticks", n, 1);
        chk("dis_last_tick_cyc", l, d - 1);
        cnt_a = 0;
        for (int k = 0; k < 1000; k++) begin @(negedge clk); if (tick_o[2]) cnt_a++; end
        chk("dis_quiet", cnt_a, 0);
        chk("dis_active", ch_active[2], 0);

        // Two channels on the same tap stay phase-aligned.
        send_cfg(0, 4, 1'b1, t); wait_done(0, d, n, l);
        send_cfg(3, 4, 1'b1, t); wait_done(3, d, n, l);
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 512; k++) begin
            @(negedge clk);
            if (tick_o[0]) cnt_a++;
            if (tick_o[0] != tick_o[3]) cnt_b++;
        end
        chk("sel4_count_512", cnt_a, 4);
        chk("sel4_coherent", cnt_b, 0);

        // Reset while a config is waiting for its boundary.
        send_cfg(3, 5, 1'b1, t);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_wait_ready", cfg_ready, 1);
        chk("rst_wait_active", ch_active, 0);
        cnt_a = 0;
        for (int k = 0; k < 10; k++) begin @(negedge clk); if (cfg_done) cnt_a++; end
        chk("rst_wait_no_done", cnt_a, 0);

        // Randomised traffic; the model above checks every cycle.
        for (int r = 0; r < 40; r++) begin
            int ch, sel;
            bit en;
            ch  = $urandom_range(0, 3);
            sel = ($urandom_range(0, 7) == 0) ? $urandom_range(21, 31) : $urandom_range(0, 5);
            en  = ($urandom_range(0, 3) != 0);
            send_cfg(ch, sel, en, t);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        repeat (600) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
